ifm_sparse_loader: RTL

- Write-side producer for the IFM sparse memory.
- Accepts dense IFM bytes from the input stream using a valid/ready handshake.
- Encodes each bus beat into a sparsemap plus nonzero bytes compacted toward the low end.
- Drives the memory write port (data, valid, dat count, chunk count) to fill a programmed number of chunks, then pulses done.

---
 rtl/ifm_sparse_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ifm_sparse_loader.sv
// IFM sparse-memory write producer: encodes dense bus beats into sparsemap + compacted
// nonzero bytes and streams them into a programmed number of chunk slots.

module ifm_sparse_lane #(
    parameter int BUS_SIZE = 32,
    parameter int PW       = 6,
    parameter int LANE     = 0
) (
    input  logic [BUS_SIZE-1:0][7:0]   bytes_i,
    input  logic [BUS_SIZE-1:0]        nz_i,
    input  logic [BUS_SIZE-1:0][PW-1:0] pos_i,
    output logic [7:0]                 byte_o
);
    // Exactly one nonzero byte can land in this lane, so OR-ing the matches is a mux.
    always_comb begin
        byte_o = 8'h00;
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (nz_i[i] && (pos_i[i] == PW'(LANE)))
                byte_o = byte_o | bytes_i[i];
        end
    end
endmodule

module ifm_sparse_loader #(
    parameter int BUS_SIZE  = 32,
    parameter int MEM_SIZE  = 128,
    parameter int CHUNK_NUM = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [$clog2(CHUNK_NUM):0]       cfg_chunk_num_i,
    input  logic [BUS_SIZE*8-1:0]            in_data_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    output logic [BUS_SIZE-1:0]              wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]            wr_nonzero_data_o,
    output logic                             wr_valid_o,
    output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0] wr_dat_count_o,
    output logic [$clog2(CHUNK_NUM)-1:0]     wr_chunk_count_o,
    output logic                             busy_o,
    output logic                             done_o
);
    localparam int DAT_CYC_NUM = MEM_SIZE / BUS_SIZE;
    localparam int DW  = $clog2(DAT_CYC_NUM);
    localparam int CHW = $clog2(CHUNK_NUM);
    localparam int CW  = CHW + 1;
    localparam int PW  = $clog2(BUS_SIZE) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  n_tgt;
    logic [DW-1:0]  dat_cnt;
    logic [CHW-1:0] chunk_cnt;
    logic [CW-1:0]  cfg_clamped;
    logic           accept;
    logic           last_dat;
    logic           last_chunk;

    logic [BUS_SIZE-1:0][7:0]    in_bytes;
    logic [BUS_SIZE-1:0][7:0]    enc_bytes;
    logic [BUS_SIZE-1:0]         nz;
    logic [BUS_SIZE-1:0][PW-1:0] pos;
    logic [PW-1:0]               pos_acc;

    assign in_bytes = in_data_i;

    // pos[i] = number of nonzero bytes below byte i, i.e. its compacted destination.
    always_comb begin
        pos_acc = '0;
        nz      = '0;
        pos     = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            nz[i]   = |in_bytes[i];
            pos[i]  = pos_acc;
            pos_acc = pos_acc + PW'(nz[i]);
        end
    end

    for (genvar k = 0; k < BUS_SIZE; k++) begin : g_lane
        ifm_sparse_lane #(
            .BUS_SIZE (BUS_SIZE),
            .PW       (PW),
            .LANE     (k)
        ) u_lane (
            .bytes_i (in_bytes),
            .nz_i    (nz),
            .pos_i   (pos),
            .byte_o  (enc_bytes[k])
        );
    end

    assign cfg_clamped = (cfg_chunk_num_i > CW'(CHUNK_NUM)) ? CW'(CHUNK_NUM) : cfg_chunk_num_i;
    assign accept      = (state == ST_LOAD) && in_valid_i;
    assign last_dat    = (dat_cnt == DW'(DAT_CYC_NUM - 1));
    assign last_chunk  = ({1'b0, chunk_cnt} == (n_tgt - CW'(1)));

    assign in_ready_o = (state == ST_LOAD);
    assign busy_o     = (state != ST_IDLE);
    assign done_o     = (state == ST_DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state             <= ST_IDLE;
            n_tgt             <= '0;
            dat_cnt           <= '0;
            chunk_cnt         <= '0;
            wr_valid_o        <= 1'b0;
            wr_sparsemap_o    <= '0;
            wr_nonzero_data_o <= '0;
            wr_dat_count_o    <= '0;
            wr_chunk_count_o  <= '0;
        end else begin
            wr_valid_o <= accept;
            if (accept) begin
                wr_sparsemap_o    <= nz;
                wr_nonzero_data_o <= enc_bytes;
                wr_dat_count_o    <= dat_cnt;
                wr_chunk_count_o  <= chunk_cnt;
            end
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        n_tgt     <= cfg_clamped;
                        dat_cnt   <= '0;
                        chunk_cnt <= '0;
                        state     <= (cfg_clamped == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid_i) begin
                        if (last_dat) begin
                            dat_cnt   <= '0;
                            chunk_cnt <= chunk_cnt + CHW'(1);
                            if (last_chunk)
                                state <= ST_DONE;
                        end else begin
                            dat_cnt <= dat_cnt + DW'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
